// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues reads to a 1-cycle synchronous ROM and
// buffers returned words in a small prefetch FIFO handed to the core over valid/ready.
module instr_fetch #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           INSTR_WIDTH = 16,
  parameter int unsigned           FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthOcc = FIFO_DEPTH[CntW:0];

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic                   inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [INSTR_WIDTH-1:0] last_data_q, last_data_d;
  logic [ADDR_WIDTH-1:0]  last_pc_q, last_pc_d;

  logic [INSTR_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc_q   [FIFO_DEPTH];

  logic          pop_raw, pop, push;
  logic [CntW:0] occupancy;

  always_comb begin
    instr_valid = (count_q != '0);
    pop_raw     = instr_valid & instr_ready;
    pop         = pop_raw & ~redirect_valid;
    push        = inflight_q & ~redirect_valid;
    // Counting the in-flight word reserves its slot, so a response always has room.
    occupancy   = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop_raw};
    mem_req     = rst & ~redirect_valid & (occupancy < DepthOcc);
    mem_addr    = fetch_pc_q;
    // Outputs hold the last presented word once the FIFO drains.
    instr_data  = instr_valid ? fifo_data_q[rd_ptr_q] : last_data_q;
    instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]   : last_pc_q;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = mem_req;
    inflight_pc_d = fetch_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    last_data_d   = instr_data;
    last_pc_d     = instr_pc;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (mem_req) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      if (push)    wr_ptr_d   = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d   = rd_ptr_q + PtrW'(1);
      count_d = count_q + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      last_data_q   <= '0;
      last_pc_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      last_data_q   <= last_data_d;
      last_pc_q     <= last_pc_d;
    end
  end

  // Storage is only read while count is non-zero, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_rdata;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule
